// File: rtl/vproc_bus_pkg.sv
// Shared types and constants for the VProc bus responder and its memory.
package vproc_bus_pkg;

  localparam int          WAIT_W = 4;
  localparam logic [31:0] RD_OOR = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    TURN = 2'd3
  } state_t;

endpackage

// File: rtl/vproc_mem_array.sv
// Single-port word RAM with per-byte write lanes and a registered read port.
module vproc_mem_array #(
  parameter int MEM_AW = 10
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [MEM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**MEM_AW];

  always_ff @(posedge Clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/vproc_bus_responder.sv
// Memory slave for VProc bus requests: wait-state FSM, range decode, burst
// tracking and one-cycle acknowledges around a byte-lane RAM.
module vproc_bus_responder
  import vproc_bus_pkg::*;
#(
  parameter int          MEM_AW     = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          RD_WAIT    = 1,
  parameter int          WR_WAIT    = 0,
  parameter int          BURST_WAIT = 0
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic [31:0] Addr,
  input  logic [3:0]  BE,
  input  logic        WE,
  input  logic        RD,
  input  logic [31:0] DataOut,
  input  logic        BurstFirst,
  output logic [31:0] DataIn,
  output logic        WRAck,
  output logic        RDAck,
  output logic        Err
);

  function automatic logic in_range(input logic [31:0] a);
    return a[31:MEM_AW] == BASE_ADDR[31:MEM_AW];
  endfunction

  function automatic logic [WAIT_W-1:0] wait_sel(input logic burst, input logic first,
                                                 input logic wr);
    if (burst && !first) return WAIT_W'(BURST_WAIT);
    else if (wr)         return WAIT_W'(WR_WAIT);
    else                 return WAIT_W'(RD_WAIT);
  endfunction

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              burst_q, burst_d;
  logic              go_ack;

  // Request captured at acceptance; no reset needed on these data registers
  logic [31:0]       addr_p0;
  logic [3:0]        be_p0;
  logic [31:0]       wdata_p0;
  logic              wr_p0;
  logic              err_p0;

  logic              wrack_q, rdack_q, err_q, rd_oor_q;
  logic [31:0]       dout_q;

  logic              idle, req;
  logic [31:0]       cur_addr, cur_wdata;
  logic [3:0]        cur_be;
  logic              cur_wr, cur_err, cur_in;
  logic              mem_we;
  logic [31:0]       mem_rdata, rd_word;
  logic [WAIT_W-1:0] sel_wait;

  assign idle = (state_q == IDLE);
  assign req  = RD | WE;

  // A zero-wait access commits on the sampling edge itself, so the memory
  // port sees the live request in IDLE and the captured one afterwards.
  assign cur_addr  = idle ? Addr    : addr_p0;
  assign cur_be    = idle ? BE      : be_p0;
  assign cur_wdata = idle ? DataOut : wdata_p0;
  assign cur_wr    = idle ? WE      : wr_p0;
  assign cur_in    = in_range(cur_addr);
  assign cur_err   = idle ? (!in_range(Addr) | (RD & WE)) : err_p0;
  assign sel_wait  = wait_sel(burst_q, BurstFirst, WE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    go_ack  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (BurstFirst) burst_d = 1'b1;
          if (sel_wait == '0) begin
            state_d = ACK;
            go_ack  = 1'b1;
          end else begin
            cnt_d   = sel_wait;
            state_d = WAIT;
          end
        end else begin
          burst_d = 1'b0;
        end
      end
      WAIT: begin
        if (cnt_q <= WAIT_W'(1)) begin
          cnt_d   = '0;
          state_d = ACK;
          go_ack  = 1'b1;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      ACK:     state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset at the commit edge must suppress the write
  assign mem_we = go_ack & nReset & cur_wr & cur_in;

  vproc_mem_array #(.MEM_AW(MEM_AW)) u_mem (
    .Clk   (Clk),
    .we    (mem_we),
    .be    (cur_be),
    .addr  (cur_addr[MEM_AW-1:0]),
    .wdata (cur_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge Clk) begin
    if (idle && req) begin
      addr_p0  <= Addr;
      be_p0    <= BE;
      wdata_p0 <= DataOut;
      wr_p0    <= WE;
      err_p0   <= !in_range(Addr) | (RD & WE);
    end
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      burst_q  <= 1'b0;
      wrack_q  <= 1'b0;
      rdack_q  <= 1'b0;
      err_q    <= 1'b0;
      rd_oor_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      wrack_q <= go_ack & cur_wr;
      rdack_q <= go_ack & !cur_wr;
      err_q   <= go_ack & cur_err;
      if (go_ack) rd_oor_q <= !cur_in;
      if (rdack_q) dout_q <= rd_word;
    end
  end

  // RAM output is already a register; the hold register keeps it after ACK
  assign rd_word = rd_oor_q ? RD_OOR : mem_rdata;
  assign DataIn  = rdack_q ? rd_word : dout_q;
  assign WRAck   = wrack_q;
  assign RDAck   = rdack_q;
  assign Err     = err_q;

endmodule

// File: tb/tb_vproc_bus_responder.sv
// Scoreboard bench for vproc_bus_responder: singles, byte enables, bursts,
// out-of-range, RD+WE collisions and mid-access reset.
module tb_vproc_bus_responder;

  localparam int AW   = 10;
  localparam int RD_W = 1;
  localparam int WR_W = 0;
  localparam int BU_W = 2;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic [31:0] Addr = '0;
  logic [3:0]  BE = '0;
  logic        WE = 1'b0;
  logic        RD = 1'b0;
  logic [31:0] DataOut = '0;
  logic        BurstFirst = 1'b0;
  logic [31:0] DataIn;
  logic        WRAck, RDAck, Err;

  always #5 Clk = ~Clk;

  vproc_bus_responder #(
    .MEM_AW(AW), .BASE_ADDR(32'h0), .RD_WAIT(RD_W), .WR_WAIT(WR_W), .BURST_WAIT(BU_W)
  ) dut (
    .Clk(Clk), .nReset(nReset), .Addr(Addr), .BE(BE), .WE(WE), .RD(RD),
    .DataOut(DataOut), .BurstFirst(BurstFirst), .DataIn(DataIn),
    .WRAck(WRAck), .RDAck(RDAck), .Err(Err)
  );

  typedef struct {
    bit          wr;
    logic [31:0] data;
    bit          err;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [int];
  int          n_chk = 0;
  int          n_err = 0;
  bit          in_burst = 0;
  logic [31:0] last_rd = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Drive one beat from a negedge; chained beats are driven during the
  // previous ACK cycle, so TURN and IDLE add two cycles to their latency.
  task automatic xfer(input bit w, input bit r, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] d, input bit first, input bit chained, input bit last);
    exp_t        e, got_e;
    bit          oor, got;
    int          wcnt, n;
    logic [31:0] old;
    oor  = (a >> AW) != 0;
    wcnt = (in_burst && !first) ? BU_W : (w ? WR_W : RD_W);
    if (first) in_burst = 1;
    e.wr   = w;
    e.err  = oor || (w && r);
    e.lat  = chained ? wcnt + 3 : wcnt + 1;
    e.data = '0;
    if (w) begin
      if (!oor) begin
        old = model.exists(int'(a)) ? model[int'(a)] : 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) old[8*i +: 8] = d[8*i +: 8];
        model[int'(a)] = old;
      end
    end else begin
      e.data = oor ? 32'h0 : model[int'(a)];
    end
    exp_q.push_back(e);

    WE = w; RD = r; Addr = a; BE = be; DataOut = d; BurstFirst = first;
    n = 0; got = 0;
    while (!got && n < 30) begin
      cyc();
      n++;
      if (WRAck || RDAck) got = 1;
    end
    got_e = exp_q.pop_front();
    if (!got) begin
      chk("ack_timeout", 32'd0, 32'd1);
    end else begin
      chk("latency", n, got_e.lat);
      chk("wrack", WRAck, got_e.wr);
      chk("rdack", RDAck, !got_e.wr);
      chk("err", Err, got_e.err);
      if (!got_e.wr) begin
        chk("rdata", DataIn, got_e.data);
        last_rd = got_e.data;
      end
    end
    if (last) begin
      WE = 0; RD = 0; BurstFirst = 0;
      cyc();
      chk("ack_pulse", {29'd0, WRAck, RDAck, Err}, 32'd0);
      cyc();
      cyc();
      in_burst = 0;
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_din"}, DataIn, 32'h0);
    chk({tag, "_wrack"}, WRAck, 1'b0);
    chk({tag, "_rdack"}, RDAck, 1'b0);
    chk({tag, "_err"}, Err, 1'b0);
  endtask

  initial begin
    nReset = 0;
    repeat (3) cyc();
    chk_outputs_zero("reset");
    nReset = 1;
    cyc();

    // single write / read
    xfer(1, 0, 32'h10, 4'hF, 32'h12345678, 0, 0, 1);
    xfer(0, 1, 32'h10, 4'hF, 32'h0, 0, 0, 1);

    // byte enables
    xfer(1, 0, 32'h20, 4'hF, 32'hFFFFFFFF, 0, 0, 1);
    xfer(1, 0, 32'h20, 4'h5, 32'hAABBCCDD, 0, 0, 1);
    xfer(0, 1, 32'h20, 4'hF, 32'h0, 0, 0, 1);
    chk("be_merge", DataIn, 32'hFFBBFFDD);

    // bursts
    for (int i = 0; i < 4; i++)
      xfer(1, 0, 32'h40 + i, 4'hF, 32'hB0000000 + 32'(i * 32'h01010101), i == 0, i != 0, i == 3);
    for (int i = 0; i < 4; i++)
      xfer(0, 1, 32'h40 + i, 4'hF, 32'h0, i == 0, i != 0, i == 3);

    // out-of-range: aliases word 0 but must not touch it
    xfer(1, 0, 32'h0, 4'hF, 32'hCAFEF00D, 0, 0, 1);
    xfer(0, 1, 32'h400, 4'hF, 32'h0, 0, 0, 1);
    xfer(1, 0, 32'h400, 4'hF, 32'h5A5A5A5A, 0, 0, 1);
    xfer(0, 1, 32'h0, 4'hF, 32'h0, 0, 0, 1);

    // BE = 0 write leaves the word alone
    xfer(1, 0, 32'h10, 4'h0, 32'h0, 0, 0, 1);
    xfer(0, 1, 32'h10, 4'hF, 32'h0, 0, 0, 1);

    // RD and WE together behave as a write with Err; DataIn keeps last read
    xfer(1, 1, 32'h30, 4'hF, 32'h0BADC0DE, 0, 0, 1);
    chk("din_hold", DataIn, last_rd);
    xfer(0, 1, 32'h30, 4'hF, 32'h0, 0, 0, 1);

    // reset at a zero-wait write's commit edge suppresses the write
    xfer(1, 0, 32'h44, 4'hF, 32'h11111111, 0, 0, 1);
    WE = 1; Addr = 32'h44; BE = 4'hF; DataOut = 32'h22222222; nReset = 0;
    cyc();
    nReset = 1; WE = 0;
    chk_outputs_zero("rst_commit");
    cyc();
    xfer(0, 1, 32'h44, 4'hF, 32'h0, 0, 0, 1);

    // reset while a read sits in WAIT abandons it
    RD = 1; Addr = 32'h10; BE = 4'hF;
    cyc();
    nReset = 0;
    cyc();
    chk_outputs_zero("rst_wait");
    nReset = 1; RD = 0;
    cyc();
    chk("rst_wait_noack", {30'd0, WRAck, RDAck}, 32'd0);
    cyc();
    xfer(0, 1, 32'h20, 4'hF, 32'h0, 0, 0, 1);
    chk("retained", DataIn, 32'hFFBBFFDD);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
